// File: rtl/buffer_skew_controller.sv
// buffer_skew_controller: sequences load/diagonal-drain of ARR_SIZE row buffers; BUF_CTRL_STALL_EN adds a drain stall input.
module buffer_skew_controller #(
  parameter int ARR_SIZE    = 4,
  parameter int QUEUE_DEPTH = ARR_SIZE * 2,
  parameter int ADDR_WIDTH  = $clog2(QUEUE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef BUF_CTRL_STALL_EN
  input  logic                    stall,
`endif
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     len,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*ARR_SIZE-1:0]   buf_state,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int TW = $clog2(QUEUE_DEPTH + ARR_SIZE) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;
  state_t state, next;
  logic [ADDR_WIDTH:0] len_q, load_cnt;
  logic [TW-1:0] t;
  logic stall_i, legal, take, beat, last_beat, run, drain_end;
  logic [2*ARR_SIZE-1:0] pop_bs, bs_next;
`ifdef BUF_CTRL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif
  assign legal     = len != '0 && len <= (ADDR_WIDTH+1)'(QUEUE_DEPTH);
  // the done cycle is still observably FIN, so a start there is ignored too
  assign take      = state == IDLE && start && !done;
  assign beat      = state == LOAD && in_valid;
  assign last_beat = beat && load_cnt + 1'b1 == len_q;
  assign run       = state == DRAIN && !stall_i;
  assign drain_end = run && t == TW'(len_q) + TW'(ARR_SIZE) - TW'(2);
  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    assign pop_bs[2*i+:2] = {run && t >= TW'(i) && t < TW'(i) + TW'(len_q), 1'b0};
  end
  assign bs_next = beat ? {ARR_SIZE{2'b01}} : pop_bs;
  always_comb
    next = state == IDLE  ? (take && legal ? LOAD : IDLE) :
           state == LOAD  ? (last_beat ? DRAIN : LOAD) :
           state == DRAIN ? (drain_end ? FIN : DRAIN) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      buf_state <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len_q     <= '0;
      load_cnt  <= '0;
      t         <= '0;
    end else begin
      state     <= next;
      in_ready  <= next == LOAD;
      busy      <= next != IDLE || state == FIN;
      done      <= state == FIN;
      err       <= take && !legal;
      buf_state <= bs_next;
      if (take && legal) begin
        len_q    <= len;
        load_cnt <= '0;
        t        <= '0;
      end
      if (beat) load_cnt <= load_cnt + 1'b1;
      if (run) t <= t + 1'b1;
    end
  end
endmodule

// File: tb/tb_buffer_skew_controller.sv
// tb_buffer_skew_controller: randomized timeline-model bench for buffer_skew_controller.
module tb_buffer_skew_controller;
  localparam int N = 4, QD = 8, AW = 3;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [AW:0] len = '0;
`ifdef BUF_CTRL_STALL_EN
  logic stall = 0;
`endif
  logic in_ready, busy, done, err;
  logic [2*N-1:0] buf_state;
  int total = 0, bad = 0;

  buffer_skew_controller #(.ARR_SIZE(N)) dut (
    .clk(clk), .rst(rst),
`ifdef BUF_CTRL_STALL_EN
    .stall(stall),
`endif
    .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .buf_state(buf_state), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Builds the expected per-cycle output timeline of one batch, then drives it.
  // vmode: 0 steady valid, 1 toggling, 2 random. smode: 0 none, 1 random, 2 three stalls at t=1.
  task automatic run_batch(input int L, input int vmode, input bit rstart, input int smode, input string tag);
    bit v[128], stl[128], sst[128], erdy[128], ebusy[128], edone[128];
    logic [AW:0] sl[128];
    logic [2*N-1:0] ebs[128];
    int cnt, e, t, m, ns, d, n;
    int pushes[N], pops[N];
    for (int k = 0; k < 128; k++) begin
      v[k] = 1'($urandom % 2); stl[k] = 0; sst[k] = 0; sl[k] = (AW+1)'($urandom);
      erdy[k] = 0; ebusy[k] = 0; edone[k] = 0; ebs[k] = '0;
    end
    for (int i = 0; i < N; i++) begin pushes[i] = 0; pops[i] = 0; end
    cnt = 0; n = 1;
    while (cnt < L) begin
      v[n] = vmode == 0 ? 1'b1 : vmode == 1 ? 1'(n % 2) : (n > 20 ? 1'b1 : 1'($urandom % 2));
      erdy[n] = 1;
      if (v[n]) begin cnt++; ebs[n+1] = {N{2'b01}}; end
      n++;
    end
    e = n - 1; d = L + N - 1; t = 0; m = e + 1; ns = 0;
    while (t < d) begin
`ifdef BUF_CTRL_STALL_EN
      stl[m] = smode == 1 ? (ns < 10 && $urandom % 3 == 0) : smode == 2 ? (t == 1 && ns < 3) : 1'b0;
`endif
      if (stl[m]) begin
        ns++;
      end else begin
        for (int i = 0; i < N; i++) ebs[m+1][2*i+:2] = (t >= i && t < i + L) ? 2'b10 : 2'b00;
        t++;
      end
      m++;
    end
    edone[m+1] = 1;
    for (int k = 1; k <= m + 1; k++) begin
      ebusy[k] = 1;
      if (rstart) sst[k] = ($urandom % 4 == 0);
    end
    for (int k = 0; k <= m + 2; k++) begin
      step;
      total += 4;
      if (buf_state !== ebs[k]) begin bad++; $display("FAIL %s buf_state n=%0d got %h want %h", tag, k, buf_state, ebs[k]); end
      if (in_ready !== erdy[k]) begin bad++; $display("FAIL %s in_ready n=%0d got %b want %b", tag, k, in_ready, erdy[k]); end
      if (busy !== ebusy[k]) begin bad++; $display("FAIL %s busy n=%0d got %b want %b", tag, k, busy, ebusy[k]); end
      if (done !== edone[k] || err !== 1'b0) begin bad++; $display("FAIL %s done/err n=%0d got %b/%b want %b/0", tag, k, done, err, edone[k]); end
      for (int i = 0; i < N; i++) begin
        if (buf_state[2*i+:2] == 2'b01) pushes[i]++;
        if (buf_state[2*i+:2] == 2'b10) pops[i]++;
      end
      start = k == 0 ? 1'b1 : sst[k];
      len = k == 0 ? (AW+1)'(L) : sl[k];
      in_valid = v[k];
`ifdef BUF_CTRL_STALL_EN
      stall = stl[k];
`endif
    end
    start = 0; in_valid = 0;
`ifdef BUF_CTRL_STALL_EN
    stall = 0;
`endif
    for (int i = 0; i < N; i++) begin
      total++;
      if (pushes[i] != L || pops[i] != L) begin
        bad++;
        $display("FAIL %s lane%0d push/pop got %0d/%0d want %0d/%0d", tag, i, pushes[i], pops[i], L, L);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; start = 1; len = 3; in_valid = 1;
    step; step;
    total++;
    if ({buf_state, in_ready, busy, done, err} !== '0) begin
      bad++; $display("FAIL reset outputs got %h want 0", {buf_state, in_ready, busy, done, err});
    end
    rst = 0; start = 0; in_valid = 0;
    step;
    total++;
    if ({buf_state, in_ready, busy, done, err} !== '0) begin
      bad++; $display("FAIL reset_idle outputs got %h want 0", {buf_state, in_ready, busy, done, err});
    end
  endtask

  task automatic test_basic;
    run_batch(3, 0, 0, 0, "basic");
  endtask

  task automatic test_illegal;
    logic [AW:0] bl[3];
    bl[0] = 0; bl[1] = 9; bl[2] = 15;
    for (int j = 0; j < 3; j++) begin
      start = 1; len = bl[j];
      step;
      start = 0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || buf_state !== '0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL illegal len=%0d err/busy/bs got %b/%b/%h want 1/0/00", bl[j], err, busy, buf_state);
      end
      step;
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL illegal_after len=%0d err/busy got %b/%b want 0/0", bl[j], err, busy);
      end
    end
  endtask

  task automatic test_toggle;
    run_batch(8, 1, 0, 0, "toggle");
  endtask

  task automatic test_mid_reset;
    start = 1; len = 3; in_valid = 1;
    for (int k = 1; k <= 6; k++) begin
      step;
      start = 0;
    end
    total++;
    if (buf_state !== 8'b0000_1010) begin
      bad++; $display("FAIL midrst_pre buf_state got %h want 0a", buf_state);
    end
    rst = 1;
    step;
    rst = 0; in_valid = 0;
    total++;
    if ({buf_state, in_ready, busy, done, err} !== '0) begin
      bad++; $display("FAIL midrst outputs got %h want 0", {buf_state, in_ready, busy, done, err});
    end
    for (int k = 0; k < 6; k++) begin
      step;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || buf_state !== '0) begin
        bad++; $display("FAIL midrst_quiet k=%0d done/busy/bs got %b/%b/%h want 0/0/00", k, done, busy, buf_state);
      end
    end
    run_batch(2, 0, 0, 0, "post_rst");
  endtask

  task automatic test_ignored_start;
    run_batch(3, 0, 1, 0, "ign_start");
  endtask

  task automatic test_stall;
`ifdef BUF_CTRL_STALL_EN
    run_batch(2, 0, 0, 2, "stall");
`endif
  endtask

  task automatic test_random;
    for (int r = 0; r < 20; r++)
      run_batch(int'($urandom_range(1, QD)), 2, 1, 1, "random");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_illegal;
    test_toggle;
    test_mid_reset;
    test_ignored_start;
    test_stall;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buffer_skew_controller.md
BUFFER_SKEW_CONTROLLER -- requirements
Module: buffer_skew_controller

Interface
REQ-001 SHALL have parameter ARR_SIZE, default 4, number of row buffers (lanes) sequenced.
REQ-002 SHALL have derived parameter QUEUE_DEPTH, default ARR_SIZE*2, per-buffer entry capacity.
REQ-003 SHALL have derived parameter ADDR_WIDTH, default $clog2(QUEUE_DEPTH), count width base.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load/drain batch.
REQ-007 SHALL have port len  input  ADDR_WIDTH+1  entries per lane for the batch; sampled with start.
REQ-008 SHALL have port in_valid  input  1  host word slice present on all lanes this cycle.
REQ-009 SHALL have port in_ready  output  1  controller accepts a load beat this cycle.
REQ-010 SHALL have port buf_state  output  2*ARR_SIZE  per-lane buffer command; lane i at bits [2i+1:2i]; 00 idle/zero, 01 push, 10 pop.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at batch completion.
REQ-013 SHALL have port err  output  1  one-cycle pulse on an illegal start.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DRAIN, FIN.
REQ-015 IDLE: buf_state all 00, in_ready 0; start with 1<=len<=QUEUE_DEPTH latches len, clears counters, enters LOAD next cycle.
REQ-016 IDLE: start with len==0 or len>QUEUE_DEPTH pulses err the next cycle and stays IDLE.
REQ-017 start outside IDLE SHALL be ignored (no err, no relatch).
REQ-018 LOAD: in_ready=1; cycle with in_valid=1 drives all lanes 01 and increments load_cnt; in_valid=0 drives all lanes 00, load_cnt held.
REQ-019 LOAD: the beat making load_cnt equal latched len SHALL be the last push; FSM enters DRAIN next cycle with in_ready=0.
REQ-020 DRAIN: drain counter t runs 0..len+ARR_SIZE-2, one per cycle; lane i SHALL be 10 when i<=t<i+len, else 00 (diagonal skew of one cycle per lane).
REQ-021 DRAIN: after cycle t=len+ARR_SIZE-2, FSM enters FIN.
REQ-022 FIN: buf_state all 00, done=1 for exactly one cycle, then IDLE; start in FIN ignored.
REQ-023 Per-lane push count and pop count per batch SHALL each equal len; no lane ever exceeds QUEUE_DEPTH occupancy.
REQ-024 Outputs SHALL be registered; buf_state changes only on clk edges.

Reset
REQ-025 rst SHALL force IDLE, buf_state 0, in_ready 0, busy 0, done 0, err 0, all counters and latched len 0.
REQ-026 rst mid-LOAD or mid-DRAIN SHALL abort the batch with no done pulse; rst has priority over start.

Configuration
REQ-027 Macro BUF_CTRL_STALL_EN defined: adds input port stall (1 bit); in DRAIN with stall=1, all lanes 00 and t frozen, resuming unchanged when stall=0; stall ignored in other states.
REQ-028 Macro BUF_CTRL_STALL_EN undefined: no stall port; DRAIN advances every cycle.

Verification (ARR_SIZE=4)
REQ-029 rst then start, len=3, in_valid=1 steady -> 3 cycles buf_state=0x55, then 6 DRAIN cycles: lane0 10 at t=0..2, lane3 10 at t=3..5; done pulse once; busy low after.
REQ-030 start len=0, then start len=9 -> err pulses twice, busy stays 0, buf_state stays 0.
REQ-031 len=8, in_valid toggling 1,0 -> lanes alternate 01/00, exactly 8 pushes, DRAIN 11 cycles, 8 pops per lane.
REQ-032 rst asserted at DRAIN t=2 -> next cycle all outputs 0, no done; fresh start len=2 completes normally.
REQ-033 With BUF_CTRL_STALL_EN, len=2, stall high 3 cycles at t=1 -> all lanes 00 for 3 cycles, DRAIN total 8 cycles, pop counts per lane = 2.
REQ-034 start asserted during LOAD and DRAIN -> ignored; batch timing identical to REQ-029.
